// File: rtl/rand_lfsr_seq.sv
// rand_lfsr_seq: WIDTH-bit shift/LFSR register that runs a requested number of shifts on a start/busy/done handshake.
//
// Ports:
//   clk             - clock, rising edge
//   rst             - asynchronous active-low reset
//   load            - load seed_in into the register and clear the shift counter (aborts a run)
//   seed_in         - seed value
//   start           - request a run of `steps` shifts (ignored unless idle)
//   steps           - number of shifts, sampled with start
//   mode            - 0: shift with zero fill, 1: LFSR feedback; sampled with start
//   busy            - high while a run is in progress
//   done            - one-cycle pulse after the final shift
//   data_out        - current register value
//   result          - top RES_W bits of the register
//   shift_count_out - shifts performed since the last start or load
//
// Build option: define RAND_LOCKUP_GUARD_EN to substitute SEED_DEFAULT for an
// all-zero seed on load, and for an all-zero state when starting in LFSR mode.
module rand_lfsr_seq #(
    parameter int WIDTH = 6,
    parameter logic [WIDTH-1:0] TAPS = 6'b101010,
    parameter int RES_W = 2,
    parameter int CNT_W = 3,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic [RES_W-1:0] result,
    output logic [CNT_W-1:0] shift_count_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

`ifdef RAND_LOCKUP_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    fsm_t fsm, fsm_n;
    logic [WIDTH-1:0] sr, sr_n, seed_eff, start_sr, shifted;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, steps_q, steps_n;
    logic mode_q, mode_n;

    assign seed_eff = (GUARD && seed_in == '0) ? SEED_DEFAULT : seed_in;
    assign start_sr = (GUARD && mode && sr == '0) ? SEED_DEFAULT : sr;
    assign shifted  = {sr[WIDTH-2:0], mode_q & (^(sr & TAPS))};
    assign cnt_inc  = cnt + CNT_W'(1);

    // Load wins in every state: it reseeds, clears the counter and abandons any run.
    always_comb begin
        fsm_n   = fsm;
        sr_n    = sr;
        cnt_n   = cnt;
        steps_n = steps_q;
        mode_n  = mode_q;
        if (load) begin
            sr_n  = seed_eff;
            cnt_n = '0;
            fsm_n = IDLE;
        end else if (fsm == IDLE && start) begin
            sr_n    = start_sr;
            cnt_n   = '0;
            steps_n = steps;
            mode_n  = mode;
            fsm_n   = (steps == '0) ? DONE : RUN;
        end else if (fsm == RUN) begin
            sr_n  = shifted;
            cnt_n = cnt_inc;
            fsm_n = (cnt_inc == steps_q) ? DONE : RUN;
        end else if (fsm != IDLE) begin
            fsm_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm     <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            steps_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            fsm     <= fsm_n;
            sr      <= sr_n;
            cnt     <= cnt_n;
            steps_q <= steps_n;
            mode_q  <= mode_n;
        end
    end

    assign busy            = (fsm == RUN);
    assign done            = (fsm == DONE);
    assign data_out        = sr;
    assign result          = sr[WIDTH-1 -: RES_W];
    assign shift_count_out = cnt;
endmodule

// File: tb/tb_rand_lfsr_seq.sv
// tb_rand_lfsr_seq: directed self-checking bench for rand_lfsr_seq with a per-cycle expectation queue.
module tb_rand_lfsr_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [5:0] seed_in = '0;
    logic       start = 1'b0;
    logic [2:0] steps = '0;
    logic       mode = 1'b0;
    logic       busy, done;
    logic [5:0] data_out;
    logic [1:0] result;
    logic [2:0] shift_count_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [5:0] d;
        logic       b;
        logic       dn;
        logic [2:0] c;
    } exp_t;

    exp_t sb[$];

    rand_lfsr_seq dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .seed_in(seed_in),
        .start(start),
        .steps(steps),
        .mode(mode),
        .busy(busy),
        .done(done),
        .data_out(data_out),
        .result(result),
        .shift_count_out(shift_count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".data"}, 32'(data_out), 32'(e.d));
        chk({e.tag, ".result"}, 32'(result), 32'(e.d[5:4]));
        chk({e.tag, ".busy"}, 32'(busy), 32'(e.b));
        chk({e.tag, ".done"}, 32'(done), 32'(e.dn));
        chk({e.tag, ".count"}, 32'(shift_count_out), 32'(e.c));
    endtask

    // Expect the given outputs right after the next rising edge.
    task automatic cyc(input string tag, input logic [5:0] d, input logic b, input logic dn, input logic [2:0] c);
        sb.push_back('{tag, d, b, dn, c});
        @(posedge clk);
        #1;
        compare_head();
    endtask

    // Expect the given outputs now, without waiting for a clock.
    task automatic now(input string tag, input logic [5:0] d, input logic b, input logic dn, input logic [2:0] c);
        sb.push_back('{tag, d, b, dn, c});
        compare_head();
    endtask

    initial begin
        #1;
        now("rst_hold", 6'b000000, 0, 0, 0);
        cyc("rst_edge", 6'b000000, 0, 0, 0);
        rst = 1'b1;
        cyc("rst_rel", 6'b000000, 0, 0, 0);

        load = 1; seed_in = 6'b000001;
        cyc("lfsr_load", 6'b000001, 0, 0, 0);
        load = 0; start = 1; steps = 3; mode = 1;
        cyc("lfsr_e0", 6'b000001, 1, 0, 0);
        start = 0; steps = 0; mode = 0;
        cyc("lfsr_s1", 6'b000010, 1, 0, 1);
        cyc("lfsr_s2", 6'b000101, 1, 0, 2);
        cyc("lfsr_s3", 6'b001010, 0, 1, 3);
        cyc("lfsr_idle", 6'b001010, 0, 0, 3);

        load = 1; seed_in = 6'b101010;
        cyc("sh_load", 6'b101010, 0, 0, 0);
        load = 0; start = 1; steps = 2; mode = 0;
        cyc("sh_e0", 6'b101010, 1, 0, 0);
        start = 0;
        cyc("sh_s1", 6'b010100, 1, 0, 1);
        cyc("sh_s2", 6'b101000, 0, 1, 2);
        cyc("sh_idle", 6'b101000, 0, 0, 2);

        start = 1; steps = 0;
        cyc("zero_done", 6'b101000, 0, 1, 0);
        start = 0;
        cyc("zero_idle", 6'b101000, 0, 0, 0);

        load = 1; seed_in = 6'b000001;
        cyc("ign_load", 6'b000001, 0, 0, 0);
        load = 0; start = 1; steps = 2; mode = 0;
        cyc("ign_e0", 6'b000001, 1, 0, 0);
        steps = 7; mode = 1;
        cyc("ign_s1", 6'b000010, 1, 0, 1);
        cyc("ign_s2", 6'b000100, 0, 1, 2);
        cyc("ign_done", 6'b000100, 0, 0, 2);
        start = 0;
        cyc("ign_idle", 6'b000100, 0, 0, 2);

        start = 1; steps = 5; mode = 0;
        cyc("ab_e0", 6'b000100, 1, 0, 0);
        start = 0;
        cyc("ab_s1", 6'b001000, 1, 0, 1);
        cyc("ab_s2", 6'b010000, 1, 0, 2);
        load = 1; seed_in = 6'b110011;
        cyc("ab_load", 6'b110011, 0, 0, 0);
        load = 0;
        cyc("ab_after1", 6'b110011, 0, 0, 0);
        cyc("ab_after2", 6'b110011, 0, 0, 0);

        start = 1; steps = 5; mode = 0;
        cyc("ar_e0", 6'b110011, 1, 0, 0);
        start = 0;
        cyc("ar_s1", 6'b100110, 1, 0, 1);
        cyc("ar_s2", 6'b001100, 1, 0, 2);
        #2 rst = 1'b0;
        #1;
        now("ar_async", 6'b000000, 0, 0, 0);
        cyc("ar_hold", 6'b000000, 0, 0, 0);
        rst = 1'b1;
        cyc("ar_rel1", 6'b000000, 0, 0, 0);
        cyc("ar_rel2", 6'b000000, 0, 0, 0);
        cyc("ar_rel3", 6'b000000, 0, 0, 0);

        load = 1; seed_in = 6'b000001; start = 1; steps = 3;
        cyc("prio_load", 6'b000001, 0, 0, 0);
        load = 0; start = 0;
        cyc("prio_idle", 6'b000001, 0, 0, 0);

`ifdef RAND_LOCKUP_GUARD_EN
        load = 1; seed_in = 6'b000000;
        cyc("lk_load", 6'b000001, 0, 0, 0);
        load = 0; start = 1; steps = 1; mode = 1;
        cyc("lk_e0", 6'b000001, 1, 0, 0);
        start = 0;
        cyc("lk_s1", 6'b000010, 0, 1, 1);
        cyc("lk_idle", 6'b000010, 0, 0, 1);
`else
        load = 1; seed_in = 6'b000000;
        cyc("lk_load", 6'b000000, 0, 0, 0);
        load = 0; start = 1; steps = 1; mode = 1;
        cyc("lk_e0", 6'b000000, 1, 0, 0);
        start = 0;
        cyc("lk_s1", 6'b000000, 0, 1, 1);
        cyc("lk_idle", 6'b000000, 0, 0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
